// File: rtl/bsa_op_sequencer.sv
// -----------------------------------------------------------------------------
// bsa_op_sequencer
//
// Upstream controller for the 4-bit bit-serial adder. Operand pairs arrive on a
// valid/ready stream and are buffered in a small circular FIFO. Each pair is
// issued to the adder with a one-cycle load+start pulse. The sequencer then
// waits for the adder's done pulse, bounded by a timeout, and presents the
// registered sum plus overflow and error flags on a valid/ready result stream.
// Only one addition is in flight at a time.
//
// Parameters
//   FIFO_DEPTH : operand FIFO entries (power of two, >= 2)
//   TIMEOUT    : cycles spent in WAIT without add_done before abort (1..15)
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : operand stream handshake (in_ready = FIFO not full)
//   in_a, in_b            : 4-bit operands
//   add_load, add_start   : one-cycle strobes to the adder
//   add_a, add_b          : operands held for the adder during the operation
//   add_sum, add_done     : adder result, valid in the add_done cycle
//   out_valid/out_ready   : result stream handshake
//   out_sum               : sum as received from the adder (0 on timeout)
//   out_ovf               : carry out of the issued operands
//   out_err               : timeout abort flag
//   busy                  : operation in progress or operands queued
// -----------------------------------------------------------------------------
module bsa_op_sequencer #(
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  output logic       add_load,
  output logic       add_start,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  input  logic [3:0] add_sum,
  input  logic       add_done,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_sum,
  output logic       out_ovf,
  output logic       out_err,
  output logic       busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [3:0]       TO_LAST  = 4'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t           state_r;
  logic [7:0]       fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [3:0]       ia_r;
  logic [3:0]       ib_r;
  logic [3:0]       tmo_cnt_r;
  logic             add_load_r;
  logic             add_start_r;
  logic             out_valid_r;
  logic [3:0]       out_sum_r;
  logic             out_ovf_r;
  logic             out_err_r;

  logic             push_s;
  logic             pop_s;
  logic             fifo_nonempty_s;
  logic [7:0]       fifo_head_s;
  logic [4:0]       issue_sum_s;

  // Full/empty are derived from the registered count only, so a pop in the
  // same cycle never admits a push into a full FIFO.
  assign in_ready        = (count_r != FULL_CNT);
  assign fifo_nonempty_s = (count_r != {CNT_W{1'b0}});
  assign push_s          = in_valid && in_ready;
  assign pop_s           = (state_r == ST_IDLE) && fifo_nonempty_s;
  assign fifo_head_s     = fifo_mem_r[rd_ptr_r];

  // Overflow is the carry of the issued operands, independent of add_sum.
  assign issue_sum_s = {1'b0, ia_r} + {1'b0, ib_r};

  assign add_load  = add_load_r;
  assign add_start = add_start_r;
  assign add_a     = ia_r;
  assign add_b     = ib_r;
  assign out_valid = out_valid_r;
  assign out_sum   = out_sum_r;
  assign out_ovf   = out_ovf_r;
  assign out_err   = out_err_r;
  assign busy      = (state_r != ST_IDLE) || fifo_nonempty_s;

  // Operand FIFO storage, wrapping pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= 8'd0;
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= {in_a, in_b};
        wr_ptr_r             <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Issue/wait/hold sequencing with registered adder strobes and results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      ia_r        <= 4'd0;
      ib_r        <= 4'd0;
      tmo_cnt_r   <= 4'd0;
      add_load_r  <= 1'b0;
      add_start_r <= 1'b0;
      out_valid_r <= 1'b0;
      out_sum_r   <= 4'd0;
      out_ovf_r   <= 1'b0;
      out_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (fifo_nonempty_s) begin
            // Strobes are set here so they are high for exactly the ISSUE cycle.
            ia_r        <= fifo_head_s[7:4];
            ib_r        <= fifo_head_s[3:0];
            add_load_r  <= 1'b1;
            add_start_r <= 1'b1;
            state_r     <= ST_ISSUE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          add_load_r  <= 1'b0;
          add_start_r <= 1'b0;
          tmo_cnt_r   <= 4'd0;
          state_r     <= ST_WAIT;
        end
        ST_WAIT: begin
          tmo_cnt_r <= tmo_cnt_r + 4'd1;
          if (add_done) begin
            out_sum_r   <= add_sum;
            out_ovf_r   <= issue_sum_s[4];
            out_err_r   <= 1'b0;
            out_valid_r <= 1'b1;
            state_r     <= ST_HOLD;
          end else if (tmo_cnt_r == TO_LAST) begin
            out_sum_r   <= 4'd0;
            out_ovf_r   <= 1'b0;
            out_err_r   <= 1'b1;
            out_valid_r <= 1'b1;
            state_r     <= ST_HOLD;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        default: begin
          add_load_r  <= 1'b0;
          add_start_r <= 1'b0;
          out_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bsa_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bsa_op_sequencer
//
// Self-checking bench for bsa_op_sequencer. A behavioural adder returns
// (a+b) mod 16 five cycles after sampling load+start. Expected results come
// from a queue of accepted operand pairs and plain arithmetic on them.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_bsa_op_sequencer;

  localparam int DEPTH = 2;
  localparam int TO    = 15;
  localparam logic [18:0] RST_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0,
                                     1'b0, 4'd0, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       add_load;
  logic       add_start;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic [3:0] add_sum;
  logic       add_done;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_sum;
  logic       out_ovf;
  logic       out_err;
  logic       busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bsa_op_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .add_load(add_load), .add_start(add_start), .add_a(add_a), .add_b(add_b),
    .add_sum(add_sum), .add_done(add_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_ovf(out_ovf), .out_err(out_err), .busy(busy)
  );

  // Behavioural adder: done pulse five edges after load+start is sampled.
  logic       adder_en;
  logic       spur_done;
  logic       mdl_done;
  logic [3:0] mdl_sum;
  logic [2:0] dly;
  logic [3:0] lat_a;
  logic [3:0] lat_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly <= 3'd0; mdl_done <= 1'b0; mdl_sum <= 4'd0; lat_a <= 4'd0; lat_b <= 4'd0;
    end else begin
      mdl_done <= 1'b0;
      if (add_load && add_start && adder_en) begin
        dly <= 3'd5; lat_a <= add_a; lat_b <= add_b;
      end else if (dly != 3'd0) begin
        dly <= dly - 3'd1;
        if (dly == 3'd1) begin
          mdl_done <= 1'b1;
          mdl_sum  <= lat_a + lat_b;
        end
      end
    end
  end

  // Outside the done cycle the sum bus carries junk that must not be captured.
  assign add_sum  = mdl_done ? mdl_sum : ~mdl_sum;
  assign add_done = mdl_done | spur_done;

  function automatic logic [18:0] snap();
    return {in_ready, busy, add_load, add_start, add_a, add_b,
            out_valid, out_sum, out_ovf, out_err};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_a = 4'd0; in_b = 4'd0;
    out_ready = 1'b0; spur_done = 1'b0; adder_en = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (snap() !== RST_VEC) begin
      bad++; $display("FAIL reset_vals: got %b want %b", snap(), RST_VEC);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (snap() !== RST_VEC) begin
      bad++; $display("FAIL reset_idle: got %b want %b", snap(), RST_VEC);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 4'd5; in_b = 4'd6;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if ({in_ready, busy} !== 2'b11) begin
      bad++; $display("FAIL single_busy: got %b want 11", {in_ready, busy});
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        total++;
        if ({add_load, add_start, add_a, add_b} !== {1'b1, 1'b1, 4'd5, 4'd6}) begin
          bad++; $display("FAIL single_issue: got %b want 11_0101_0110",
                          {add_load, add_start, add_a, add_b});
        end
      end
      if (k == 2) begin
        total++;
        if ({add_load, add_start, add_a, add_b} !== {1'b0, 1'b0, 4'd5, 4'd6}) begin
          bad++; $display("FAIL single_strobe_end: got %b want 00_0101_0110",
                          {add_load, add_start, add_a, add_b});
        end
      end
      total++;
      if (out_valid !== (k == 8)) begin
        bad++; $display("FAIL single_latency k=%0d: got %b want %b", k, out_valid, (k == 8));
      end
    end
    total++;
    if ({out_sum, out_ovf, out_err} !== {4'd11, 1'b0, 1'b0}) begin
      bad++; $display("FAIL single_result: got sum=%0d ovf=%b err=%b want 11 0 0",
                      out_sum, out_ovf, out_err);
    end
    @(negedge clk);
    total++;
    if ({out_valid, busy} !== 2'b00) begin
      bad++; $display("FAIL single_accept: got %b want 00", {out_valid, busy});
    end
  endtask

  // Pushes one pair and waits (bounded) for its result, then lets it be accepted.
  task automatic run_one(input logic [3:0] a, input logic [3:0] b, output logic seen,
                         output logic [3:0] s, output logic o, output logic e);
    logic r;
    seen = 1'b0; s = 4'd0; o = 1'b0; e = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; in_a = a; in_b = b;
    for (int c = 0; c < 20; c++) begin
      r = in_ready;
      @(negedge clk);
      if (r) break;
    end
    in_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) begin
        seen = 1'b1; s = out_sum; o = out_ovf; e = out_err;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    logic seen; logic [3:0] s; logic o; logic e;
    run_one(4'd15, 4'd1, seen, s, o, e);
    total++;
    if ({seen, s, o, e} !== {1'b1, 4'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL ovf_15_1: got seen=%b sum=%0d ovf=%b err=%b want 1 0 1 0", seen, s, o, e);
    end
    run_one(4'd9, 4'd9, seen, s, o, e);
    total++;
    if ({seen, s, o, e} !== {1'b1, 4'd2, 1'b1, 1'b0}) begin
      bad++; $display("FAIL ovf_9_9: got seen=%b sum=%0d ovf=%b err=%b want 1 2 1 0", seen, s, o, e);
    end
    run_one(4'd7, 4'd8, seen, s, o, e);
    total++;
    if ({seen, s, o, e} !== {1'b1, 4'd15, 1'b0, 1'b0}) begin
      bad++; $display("FAIL ovf_7_8: got seen=%b sum=%0d ovf=%b err=%b want 1 15 0 0", seen, s, o, e);
    end
  endtask

  task automatic test_timeout();
    logic seen;
    out_ready = 1'b1; adder_en = 1'b0;
    in_valid = 1'b1; in_a = 4'd3; in_b = 4'd4;
    @(negedge clk);                 // first pair pushed (edge P)
    in_a = 4'd7; in_b = 4'd8;
    @(negedge clk);                 // second pair pushed, first popped (P+1)
    in_valid = 1'b0;
    for (int k = 2; k <= TO + 2; k++) begin
      @(negedge clk);
      total++;
      if (out_valid !== (k == TO + 2)) begin
        bad++; $display("FAIL timeout_latency k=%0d: got %b want %b", k, out_valid, (k == TO + 2));
      end
      if (k == 2) adder_en = 1'b1;
    end
    total++;
    if ({out_sum, out_ovf, out_err} !== {4'd0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL timeout_result: got sum=%0d ovf=%b err=%b want 0 0 1",
                      out_sum, out_ovf, out_err);
    end
    @(negedge clk);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if ({seen, out_sum, out_ovf, out_err} !== {1'b1, 4'd15, 1'b0, 1'b0}) begin
      bad++; $display("FAIL timeout_next_op: got seen=%b sum=%0d ovf=%b err=%b want 1 15 0 0",
                      seen, out_sum, out_ovf, out_err);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [3:0] pa [4] = '{4'd1, 4'd12, 4'd5, 4'd15};
    logic [3:0] pb [4] = '{4'd2, 4'd9,  4'd6, 4'd15};
    logic [7:0] exp_q [$];
    logic [7:0] pr;
    logic [6:0] held;
    logic r;
    logic v;
    int idx = 0;
    int n = 0;
    int es;
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = pa[0]; in_b = pb[0];
    for (int c = 0; c < 30; c++) begin
      r = in_ready;
      @(negedge clk);
      if (r && idx < 4) begin
        exp_q.push_back({pa[idx], pb[idx]});
        idx++;
        if (idx < 4) begin in_a = pa[idx]; in_b = pb[idx]; end
        else in_valid = 1'b0;
      end
    end
    total++;
    if ({idx[2:0], in_ready, out_valid} !== {3'd3, 1'b0, 1'b1}) begin
      bad++; $display("FAIL bp_full: got accepted=%0d in_ready=%b out_valid=%b want 3 0 1",
                      idx, in_ready, out_valid);
    end
    held = {out_valid, out_sum, out_ovf, out_err};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if ({out_valid, out_sum, out_ovf, out_err} !== held) begin
        bad++; $display("FAIL bp_stable: got %b want %b", {out_valid, out_sum, out_ovf, out_err}, held);
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 100 && n < 4; c++) begin
      r = in_ready; v = out_valid;
      if (v) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL bp_extra_result: got sum=%0d want none", out_sum);
        end else begin
          pr = exp_q.pop_front();
          es = (int'(pr[7:4]) + int'(pr[3:0]));
          if ({out_sum, out_ovf, out_err} !== {4'(es % 16), (es > 15), 1'b0}) begin
            bad++; $display("FAIL bp_order n=%0d: got sum=%0d ovf=%b err=%b want %0d %b 0",
                            n, out_sum, out_ovf, out_err, es % 16, (es > 15));
          end
        end
        n++;
      end
      @(negedge clk);
      if (r && in_valid) begin
        exp_q.push_back({pa[idx], pb[idx]});
        idx++;
        in_valid = 1'b0;
      end
    end
    total++;
    if (n != 4) begin
      bad++; $display("FAIL bp_count: got %0d results want 4", n);
    end
  endtask

  task automatic test_random();
    localparam int N = 40;
    logic [7:0] exp_q [$];
    logic [7:0] pr;
    logic [5:0] cur;
    logic [5:0] prev_out = 6'd0;
    logic prev_v = 1'b0;
    logic prev_acc = 1'b0;
    logic r;
    logic v;
    logic push_now;
    int n_in = 0;
    int n_res = 0;
    int es;
    in_valid = 1'b1; in_a = 4'($urandom); in_b = 4'($urandom); out_ready = 1'b1;
    for (int c = 0; c < 3000 && n_res < N; c++) begin
      r = in_ready; v = out_valid; cur = {out_sum, out_ovf, out_err};
      if (prev_v && !prev_acc) begin
        total++;
        if ({v, cur} !== {1'b1, prev_out}) begin
          bad++; $display("FAIL rnd_stable: got %b want %b", {v, cur}, {1'b1, prev_out});
        end
      end
      if (v && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rnd_extra_result: got sum=%0d want none", out_sum);
        end else begin
          pr = exp_q.pop_front();
          es = int'(pr[7:4]) + int'(pr[3:0]);
          if (cur !== {4'(es % 16), (es > 15), 1'b0}) begin
            bad++; $display("FAIL rnd_result n=%0d a=%0d b=%0d: got %b want sum=%0d ovf=%b err=0",
                            n_res, pr[7:4], pr[3:0], cur, es % 16, (es > 15));
          end
        end
        n_res++;
      end
      prev_v = v; prev_acc = v && out_ready; prev_out = cur;
      push_now = in_valid && r;
      if (push_now) begin
        exp_q.push_back({in_a, in_b});
        n_in++;
      end
      @(negedge clk);
      in_valid  = (n_in < N) && ($urandom_range(0, 9) < 7);
      in_a      = 4'($urandom);
      in_b      = 4'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
    end
    total++;
    if (n_res != N) begin
      bad++; $display("FAIL rnd_count: got %0d results want %0d", n_res, N);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_spurious_reset();
    logic r;
    logic leak = 1'b0;
    int pushed = 0;
    out_ready = 1'b1; in_valid = 1'b0;
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total++;
      if ({out_valid, busy, out_sum} !== {1'b0, 1'b0, 4'd0}) begin
        bad++; $display("FAIL spurious_done: got valid=%b busy=%b sum=%0d want 0 0 0",
                        out_valid, busy, out_sum);
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 4'd2; in_b = 4'd3;
    for (int c = 0; c < 10 && pushed < 3; c++) begin
      r = in_ready;
      @(negedge clk);
      if (r) begin
        pushed++;
        in_a = in_a + 4'd1;
      end
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (snap() !== RST_VEC) begin
      bad++; $display("FAIL midop_reset: got %b want %b", snap(), RST_VEC);
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid || add_load || busy) leak = 1'b1;
    end
    total++;
    if (leak !== 1'b0) begin
      bad++; $display("FAIL reset_flush: got activity=%b want 0", leak);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_timeout();
    test_backpressure();
    test_random();
    test_spurious_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
